// File: rtl/pll_lock_sequencer.sv
// PLL start-up and supervision sequencer for the iCE40 PLL wrapper.
// Holds the system in reset until the PLL has locked and stayed locked,
// restarts the PLL on lock loss and falls back to bypass after repeated failures.
// Runs entirely on the 12 MHz reference clock.
module pll_lock_sequencer #(
    parameter int unsigned RESET_CYCLES   = 16,
    parameter int unsigned LOCK_TIMEOUT   = 12000,
    parameter int unsigned STABLE_CYCLES  = 1200,
    parameter int unsigned MAX_RETRIES    = 3,
    parameter bit          BYPASS_ON_FAIL = 1'b1
) (
    input  logic       clock_in,
    input  logic       reset,
    input  logic       pll_locked,
    input  logic       retry_req,
    output logic       pll_resetb,
    output logic       pll_bypass,
    output logic       sys_reset,
    output logic       ready,
    output logic       fault,
    output logic [1:0] retry_count,
    output logic [7:0] lock_loss_count
);

    localparam int unsigned CNT_MAX_A = (RESET_CYCLES > LOCK_TIMEOUT) ? RESET_CYCLES
                                                                      : LOCK_TIMEOUT;
    localparam int unsigned CNT_MAX   = (CNT_MAX_A > STABLE_CYCLES) ? CNT_MAX_A
                                                                    : STABLE_CYCLES;
    localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);

    // Terminal counter values: each one forces a state change, so the counter never wraps.
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STB_LAST    = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [1:0]       RETRY_LIMIT = 2'(MAX_RETRIES);

    typedef enum logic [2:0] {
        StResetPll,
        StWaitLock,
        StStable,
        StRun,
        StFault
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       retry_q, retry_d;
    logic [1:0]       retry_inc;
    logic [7:0]       loss_q, loss_d;
    logic             fail;

    logic sync1_q, locked_s_q;

    logic pll_resetb_q, pll_resetb_d;
    logic pll_bypass_q, pll_bypass_d;
    logic sys_reset_q, sys_reset_d;
    logic ready_q, ready_d;
    logic fault_q, fault_d;

    // Two-flop synchroniser for the asynchronous PLL lock pin.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            sync1_q    <= 1'b0;
            locked_s_q <= 1'b0;
        end else begin
            sync1_q    <= pll_locked;
            locked_s_q <= sync1_q;
        end
    end

    assign retry_inc = retry_q + 2'd1;

    // Next-state, counter and registered-output decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        retry_d = retry_q;
        loss_d  = loss_q;
        fail    = 1'b0;

        case (state_q)
            StResetPll: begin
                if (cnt_q == RST_LAST) state_d = StWaitLock;
            end
            StWaitLock: begin
                if (locked_s_q)             state_d = StStable;
                else if (cnt_q == TMO_LAST) fail    = 1'b1;
            end
            StStable: begin
                if (!locked_s_q)            fail    = 1'b1;
                else if (cnt_q == STB_LAST) state_d = StRun;
            end
            StRun: begin
                // Lock loss takes priority so a simultaneous retry_req still gets counted.
                if (!locked_s_q) begin
                    state_d = StResetPll;
                    if (loss_q != 8'hff) loss_d = loss_q + 8'd1;
                end else if (retry_req) begin
                    state_d = StResetPll;
                end
            end
            StFault: begin
                if (retry_req) begin
                    state_d = StResetPll;
                    retry_d = 2'd0;
                end
            end
            default: state_d = StResetPll;
        endcase

        if (fail) begin
            retry_d = retry_inc;
            state_d = (retry_inc >= RETRY_LIMIT) ? StFault : StResetPll;
        end

        // A successful lock sequence forgets earlier failures.
        if (state_d == StRun) retry_d = 2'd0;

        // Shared counter: cleared on every state change, idle outside the timed states.
        if (state_d == state_q && state_q inside {StResetPll, StWaitLock, StStable}) begin
            cnt_d = cnt_q + CNT_W'(1);
        end

        // Outputs are decoded from the next state so they change together with it.
        pll_resetb_d = state_d inside {StWaitLock, StStable, StRun};
        pll_bypass_d = (state_d == StFault) && BYPASS_ON_FAIL;
        sys_reset_d  = !((state_d == StRun) || pll_bypass_d);
        ready_d      = (state_d == StRun);
        fault_d      = (state_d == StFault);
    end

    // State, counters and output registers.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            state_q      <= StResetPll;
            cnt_q        <= '0;
            retry_q      <= 2'd0;
            loss_q       <= 8'd0;
            pll_resetb_q <= 1'b0;
            pll_bypass_q <= 1'b0;
            sys_reset_q  <= 1'b1;
            ready_q      <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retry_q      <= retry_d;
            loss_q       <= loss_d;
            pll_resetb_q <= pll_resetb_d;
            pll_bypass_q <= pll_bypass_d;
            sys_reset_q  <= sys_reset_d;
            ready_q      <= ready_d;
            fault_q      <= fault_d;
        end
    end

    assign pll_resetb      = pll_resetb_q;
    assign pll_bypass      = pll_bypass_q;
    assign sys_reset       = sys_reset_q;
    assign ready           = ready_q;
    assign fault           = fault_q;
    assign retry_count     = retry_q;
    assign lock_loss_count = loss_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Self-checking bench for pll_lock_sequencer using a queue of expected output snapshots.
module tb_pll_lock_sequencer;

    localparam int RC = 4;
    localparam int LT = 20;
    localparam int SC = 8;
    localparam int MR = 2;

    logic       clock_in   = 1'b0;
    logic       reset      = 1'b1;
    logic       pll_locked = 1'b0;
    logic       retry_req  = 1'b0;
    logic       pll_resetb;
    logic       pll_bypass;
    logic       sys_reset;
    logic       ready;
    logic       fault;
    logic [1:0] retry_count;
    logic [7:0] lock_loss_count;

    typedef struct packed {
        logic       resetb;
        logic       bypass;
        logic       sys_reset;
        logic       ready;
        logic       fault;
        logic [1:0] rc;
        logic [7:0] llc;
    } out_t;

    out_t exp_q[$];
    out_t it;
    int   vectors     = 0;
    int   miscompares = 0;

    pll_lock_sequencer #(
        .RESET_CYCLES  (RC),
        .LOCK_TIMEOUT  (LT),
        .STABLE_CYCLES (SC),
        .MAX_RETRIES   (MR),
        .BYPASS_ON_FAIL(1'b1)
    ) dut (
        .clock_in       (clock_in),
        .reset          (reset),
        .pll_locked     (pll_locked),
        .retry_req      (retry_req),
        .pll_resetb     (pll_resetb),
        .pll_bypass     (pll_bypass),
        .sys_reset      (sys_reset),
        .ready          (ready),
        .fault          (fault),
        .retry_count    (retry_count),
        .lock_loss_count(lock_loss_count)
    );

    always #5 clock_in = ~clock_in;

    function automatic out_t mk(input logic rb, input logic bp, input logic sr, input logic rd,
                                input logic ft, input logic [1:0] rc, input logic [7:0] llc);
        out_t o;
        o.resetb = rb; o.bypass = bp; o.sys_reset = sr; o.ready = rd; o.fault = ft;
        o.rc = rc; o.llc = llc;
        return o;
    endfunction

    // Expected outputs per state: RESET_PLL, WAIT_LOCK/STABLE, RUN, FAULT (bypass mode).
    function automatic out_t rst_e(input logic [1:0] rc, input logic [7:0] llc);
        return mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, rc, llc);
    endfunction
    function automatic out_t wait_e(input logic [1:0] rc, input logic [7:0] llc);
        return mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, rc, llc);
    endfunction
    function automatic out_t run_e(input logic [7:0] llc);
        return mk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, llc);
    endfunction
    function automatic out_t fault_e(input logic [7:0] llc);
        return mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'd2, llc);
    endfunction

    function automatic out_t snap();
        out_t o;
        o.resetb = pll_resetb; o.bypass = pll_bypass; o.sys_reset = sys_reset;
        o.ready = ready; o.fault = fault; o.rc = retry_count; o.llc = lock_loss_count;
        return o;
    endfunction

    // Advance one cycle and sample 1 time unit after the active edge.
    task automatic step();
        @(posedge clock_in);
        #1;
    endtask

    // Leaves the bench at the first sample after the last reset edge.
    task automatic do_reset();
        reset = 1'b1; pll_locked = 1'b0; retry_req = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; pll_locked = 1'b1; retry_req = 1'b1;
        exp_q.push_back(rst_e(2'd0, 8'd0));
        exp_q.push_back(rst_e(2'd0, 8'd0));
        for (int k = 0; k < 2; k++) begin
            step();
            it = exp_q.pop_front();
            vectors++;
            if (snap() !== it) begin
                miscompares++;
                $display("FAIL reset c%0d: got %b, want %b", k, snap(), it);
            end
        end
        reset = 1'b0; pll_locked = 1'b0; retry_req = 1'b0;
    endtask

    task automatic test_clean_lock();
        do_reset();
        // Raw lock rises at c9: STABLE at c12, RUN at c20.
        for (int k = 0; k <= 21; k++)
            exp_q.push_back(k < RC ? rst_e(2'd0, 8'd0) :
                            k < 20 ? wait_e(2'd0, 8'd0) : run_e(8'd0));
        for (int k = 0; k <= 21; k++) begin
            if (k == 9) pll_locked = 1'b1;
            it = exp_q.pop_front();
            vectors++;
            if (snap() !== it) begin
                miscompares++;
                $display("FAIL clean_lock c%0d: got %b, want %b", k, snap(), it);
            end
            step();
        end
    endtask

    task automatic test_glitch();
        do_reset();
        // High c5-c9, low c10, high again: failure at c13, second attempt RUN at c26.
        for (int k = 0; k <= 26; k++)
            exp_q.push_back(k < RC ? rst_e(2'd0, 8'd0) :
                            k < 13 ? wait_e(2'd0, 8'd0) :
                            k < 17 ? rst_e(2'd1, 8'd0) :
                            k < 26 ? wait_e(2'd1, 8'd0) : run_e(8'd0));
        for (int k = 0; k <= 26; k++) begin
            if (k == 5)  pll_locked = 1'b1;
            if (k == 10) pll_locked = 1'b0;
            if (k == 11) pll_locked = 1'b1;
            it = exp_q.pop_front();
            vectors++;
            if (snap() !== it) begin
                miscompares++;
                $display("FAIL glitch c%0d: got %b, want %b", k, snap(), it);
            end
            step();
        end
    endtask

    task automatic test_never_lock();
        do_reset();
        for (int k = 0; k <= 50; k++)
            exp_q.push_back(k < RC          ? rst_e(2'd0, 8'd0) :
                            k < RC + LT     ? wait_e(2'd0, 8'd0) :
                            k < 2 * RC + LT ? rst_e(2'd1, 8'd0) :
                            k < 2 * (RC + LT) ? wait_e(2'd1, 8'd0) : fault_e(8'd0));
        for (int k = 0; k <= 50; k++) begin
            it = exp_q.pop_front();
            vectors++;
            if (snap() !== it) begin
                miscompares++;
                $display("FAIL never_lock c%0d: got %b, want %b", k, snap(), it);
            end
            step();
        end
    endtask

    // Starts in FAULT as left by test_never_lock.
    task automatic test_fault_retry();
        for (int k = 0; k <= 25; k++)
            exp_q.push_back(k == 0      ? fault_e(8'd0) :
                            k <= RC     ? rst_e(2'd0, 8'd0) :
                            k <= RC + LT ? wait_e(2'd0, 8'd0) : rst_e(2'd1, 8'd0));
        for (int k = 0; k <= 25; k++) begin
            retry_req = (k == 0) || (k == 10);
            it = exp_q.pop_front();
            vectors++;
            if (snap() !== it) begin
                miscompares++;
                $display("FAIL fault_retry c%0d: got %b, want %b", k, snap(), it);
            end
            step();
        end
        retry_req = 1'b0;
    endtask

    task automatic test_lock_loss();
        do_reset();
        pll_locked = 1'b1;
        for (int w = 0; w < 40 && ready !== 1'b1; w++) step();
        vectors++;
        if (ready !== 1'b1) begin
            miscompares++;
            $display("FAIL lock_loss_first_run: ready got %b, want 1", ready);
        end
        for (int n = 0; n < 300; n++) begin
            int prev;
            int nxt;
            prev = (n < 255) ? n : 255;
            nxt  = (n + 1 < 255) ? n + 1 : 255;
            for (int k = 0; k < 3; k++) exp_q.push_back(run_e(8'(prev)));
            exp_q.push_back(rst_e(2'd0, 8'(nxt)));
            pll_locked = 1'b0;
            for (int k = 0; k < 4; k++) begin
                it = exp_q.pop_front();
                vectors++;
                if (snap() !== it) begin
                    miscompares++;
                    $display("FAIL lock_loss n%0d t+%0d: got %b, want %b", n, k, snap(), it);
                end
                step();
                if (k == 0) pll_locked = 1'b1;
            end
            for (int w = 0; w < 40 && ready !== 1'b1; w++) step();
            vectors++;
            if (ready !== 1'b1) begin
                miscompares++;
                $display("FAIL lock_loss_rerun n%0d: ready got %b, want 1", n, ready);
                break;
            end
        end
        exp_q.push_back(run_e(8'd255));
        it = exp_q.pop_front();
        vectors++;
        if (snap() !== it) begin
            miscompares++;
            $display("FAIL lock_loss_saturate: got %b, want %b", snap(), it);
        end
    endtask

    task automatic test_reset_mid_stable();
        do_reset();
        pll_locked = 1'b1;
        for (int w = 0; w < 40 && ready !== 1'b1; w++) step();
        // One lock loss so the count is non-zero; the resequence is in STABLE at t+10.
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        exp_q.push_back(wait_e(2'd0, 8'd1));
        exp_q.push_back(rst_e(2'd0, 8'd0));
        repeat (9) step();
        it = exp_q.pop_front();
        vectors++;
        if (snap() !== it) begin
            miscompares++;
            $display("FAIL mid_stable_before: got %b, want %b", snap(), it);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        it = exp_q.pop_front();
        vectors++;
        if (snap() !== it) begin
            miscompares++;
            $display("FAIL mid_stable_reset: got %b, want %b", snap(), it);
        end
    endtask

    // Continues with the lock held after test_reset_mid_stable.
    task automatic test_back_to_back();
        for (int w = 0; w < 40 && ready !== 1'b1; w++) step();
        // retry_req alone in RUN: restart without counting a lock loss.
        exp_q.push_back(run_e(8'd0));
        exp_q.push_back(rst_e(2'd0, 8'd0));
        retry_req = 1'b1;
        for (int k = 0; k < 2; k++) begin
            it = exp_q.pop_front();
            vectors++;
            if (snap() !== it) begin
                miscompares++;
                $display("FAIL run_retry t+%0d: got %b, want %b", k, snap(), it);
            end
            step();
            retry_req = 1'b0;
        end
        for (int w = 0; w < 40 && ready !== 1'b1; w++) step();
        // Lock loss and retry_req seen by the FSM in the same cycle (t+2): counted once.
        for (int k = 0; k < 3; k++) exp_q.push_back(run_e(8'd0));
        exp_q.push_back(rst_e(2'd0, 8'd1));
        pll_locked = 1'b0;
        for (int k = 0; k < 4; k++) begin
            it = exp_q.pop_front();
            vectors++;
            if (snap() !== it) begin
                miscompares++;
                $display("FAIL loss_and_retry t+%0d: got %b, want %b", k, snap(), it);
            end
            step();
            if (k == 0) pll_locked = 1'b1;
            if (k == 1) retry_req = 1'b1;
            if (k == 2) retry_req = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_clean_lock();
        test_glitch();
        test_never_lock();
        test_fault_retry();
        test_lock_loss();
        test_reset_mid_stable();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pll_lock_sequencer.md
Name: pll_lock_sequencer

Overview:
- Controls the iCE40 PLL wrapper: drives its RESETB and BYPASS pins and watches its LOCK output.
- Holds the system reset until the PLL has locked and stayed locked for a set time.
- Restarts the PLL when lock is lost. Falls back to bypass after repeated failures.
- Runs on the 12 MHz reference clock, which is the only clock that stays valid while the PLL output is unstable.

Parameters:
RESET_CYCLES, 16, cycles pll_resetb is held low on each PLL restart (>=1)
LOCK_TIMEOUT, 12000, cycles allowed in WAIT_LOCK before the attempt fails (1 ms at 12 MHz)
STABLE_CYCLES, 1200, consecutive synchronised-lock cycles required before release (100 us)
MAX_RETRIES, 3, failed attempts before entering FAULT (1..3)
BYPASS_ON_FAIL, 1, 1 = enter bypass in FAULT and release sys_reset; 0 = keep sys_reset asserted

Ports:
clock_in  input  1  12 MHz reference clock; same net as the PLL REFERENCECLK
reset  input  1  synchronous, active-high
pll_locked  input  1  raw PLL LOCK output; asynchronous to clock_in
retry_req  input  1  single-cycle request to restart the PLL
pll_resetb  output  1  to PLL RESETB; active-low
pll_bypass  output  1  to PLL BYPASS
sys_reset  output  1  active-high reset for downstream logic
ready  output  1  high only in RUN
fault  output  1  high only in FAULT
retry_count  output  2  failed attempts since the last success or retry_req
lock_loss_count  output  8  count of lock losses in RUN; saturates at 255

Behaviour:
- One clock and a synchronous active-high reset. All outputs are registered.
- Reset values: state=RESET_PLL, pll_resetb=0, pll_bypass=0, sys_reset=1, ready=0, fault=0, retry_count=0, lock_loss_count=0, cycle counter=0.
- pll_locked passes through a 2-flop synchroniser; locked_s is the second flop. The FSM acts on locked_s, so it lags the raw pin by 2 cycles.
- One shared cycle counter, cleared on every state change.
- RESET_PLL:
  - pll_resetb=0, sys_reset=1, ready=0.
  - After RESET_CYCLES cycles, go to WAIT_LOCK. pll_resetb=1 from the first WAIT_LOCK cycle.
- WAIT_LOCK:
  - If locked_s=1, go to STABLE.
  - Otherwise, when the counter reaches LOCK_TIMEOUT-1, take the failure path.
- STABLE:
  - If locked_s=0 on any cycle, take the failure path immediately.
  - After STABLE_CYCLES consecutive cycles with locked_s=1, go to RUN.
- Failure path:
  - retry_count increments.
  - If the new value is >= MAX_RETRIES, go to FAULT; otherwise go to RESET_PLL.
- RUN:
  - sys_reset=0, ready=1, retry_count cleared to 0.
  - If locked_s=0: lock_loss_count increments (saturating), then go to RESET_PLL. sys_reset=1 and ready=0 in the next cycle.
  - If retry_req=1: go to RESET_PLL with no lock_loss increment.
  - If both occur in the same cycle, the lock loss is counted.
- FAULT:
  - fault=1, ready=0, pll_resetb=0.
  - If BYPASS_ON_FAIL=1: pll_bypass=1 and sys_reset=0, so the design runs from the 12 MHz reference through the PLL bypass.
  - If BYPASS_ON_FAIL=0: pll_bypass=0 and sys_reset=1.
  - Exits only on retry_req or reset. retry_req goes to RESET_PLL with retry_count=0, fault=0, pll_bypass=0, sys_reset=1.
- retry_req is ignored in RESET_PLL, WAIT_LOCK and STABLE.
- Latency from the raw pll_locked rising edge at cycle t, with the FSM in WAIT_LOCK and lock held:
  - STABLE entered at t+3.
  - ready and sys_reset change at t+3+STABLE_CYCLES.
- reset in any state returns immediately to the reset values. lock_loss_count is also cleared.
- Counter width is clog2 of max(RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)+1. The counter never wraps because every terminal value forces a state change.

Test Plan:
All scenarios use RESET_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2, BYPASS_ON_FAIL=1.
1. Clean lock: release reset at cycle 0, raise pll_locked at cycle 10 and hold -> pll_resetb=0 for cycles 1-4, high from 5; ready=1 and sys_reset=0 at cycle 21; retry_count=0.
2. Glitch during STABLE: pll_locked high for 5 cycles, low for 1, then high -> retry_count=1; pll_resetb low for 4 cycles; on the second attempt ready=1 and retry_count returns to 0.
3. Never locks: pll_locked=0 throughout -> two WAIT_LOCK timeouts of 20 cycles each; then fault=1, pll_bypass=1, sys_reset=0, retry_count=2.
4. Lock loss in RUN: drop pll_locked for 1 cycle -> ready=0 and sys_reset=1 three cycles later; lock_loss_count=1; full resequence to RUN with pll_locked held high again. Repeat 300 times -> lock_loss_count=255.
5. retry_req in FAULT -> next cycle fault=0, pll_bypass=0, sys_reset=1, pll_resetb=0, retry_count=0. retry_req in WAIT_LOCK -> no effect.
6. reset asserted mid-STABLE -> next cycle all outputs equal their reset values and lock_loss_count=0. retry_req and lock loss in the same RUN cycle -> lock_loss_count increments by 1.
